// File: rtl/memctl_pkg.sv
// ============================================================================
// memctl_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the ROM-to-RAM copy controller.
//
// Contents
//   ADDR_W_DEF  default address width (1024-deep ROM and RAM)
//   DATA_W_DEF  default data width (one byte per location)
//   LEN_W_DEF   default width of the byte-count input. It is one bit wider
//               than the address so that a full-memory copy (len = 2^ADDR_W)
//               can be expressed.
//   state_e     controller state enumeration (IDLE, READ, XFER, FIN)
//   len_width() derives the byte-count width from any address width
//
// Optional feature
//   CHECKSUM_EN (macro) adds a running byte checksum output to
//   mem_copy_ctrl. Nothing in this package depends on it.
// ============================================================================
package memctl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = ADDR_W_DEF + 1;

    // IDLE : waiting for start, all outputs hold
    // READ : first ROM address presented, nothing to write yet
    // XFER : one write per cycle, next ROM address presented each cycle
    // FIN  : one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        XFER = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Width of a byte counter able to hold 0 .. 2^addr_w inclusive.
    function automatic int len_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage : memctl_pkg

// File: rtl/xfer_addr_gen.sv
// ============================================================================
// xfer_addr_gen
// ----------------------------------------------------------------------------
// Address and remaining-count counters for mem_copy_ctrl.
//
// The source counter drives the ROM address directly. The destination
// counter drives the RAM address directly. Both wrap modulo 2^ADDR_W
// through natural overflow of the ADDR_W-bit registers.
//
// Operation
//   load_i  : capture src_base_i into the source counter, keep dst_base_i
//             aside and load the remaining count with len_i. The destination
//             counter is deliberately left alone, so the RAM address keeps
//             showing the previous transfer's last address until the first
//             write.
//   prime_i : (READ cycle) advance the source counter to the second byte and
//             move the captured destination base into the destination
//             counter. The first write then lands on dst_base.
//   step_i  : (XFER cycle) one byte written this cycle. Advance both
//             counters and decrement the remaining count.
//   last_o  : the byte being written this cycle is the final one.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset, clears every register
//   load_i       accepted start with a non-zero length
//   prime_i      controller is in READ
//   step_i       controller is in XFER
//   src_base_i   first ROM address
//   dst_base_i   first RAM address
//   len_i        byte count (ADDR_W+1 bits)
//   src_addr_o   current ROM read address
//   dst_addr_o   current RAM write address
//   last_o       remaining count equals one
// ============================================================================
module xfer_addr_gen #(
    parameter int ADDR_W = memctl_pkg::ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              prime_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] src_q,      src_d;
    logic [ADDR_W-1:0] dst_q,      dst_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic [ADDR_W:0]   rem_q,      rem_d;

    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        dst_base_d = dst_base_q;
        rem_d      = rem_q;

        if (load_i) begin
            src_d      = src_base_i;
            dst_base_d = dst_base_i;
            rem_d      = len_i;
        end else if (prime_i) begin
            src_d = src_q + ADDR_ONE;
            dst_d = dst_base_q;
        end else if (step_i) begin
            src_d = src_q + ADDR_ONE;
            dst_d = dst_q + ADDR_ONE;
            rem_d = rem_q - LEN_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src_q      <= '0;
            dst_q      <= '0;
            dst_base_q <= '0;
            rem_q      <= '0;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            dst_base_q <= dst_base_d;
            rem_q      <= rem_d;
        end
    end

    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign last_o     = (rem_q == LEN_ONE);

endmodule : xfer_addr_gen

// File: rtl/mem_copy_ctrl.sv
// ============================================================================
// mem_copy_ctrl
// ----------------------------------------------------------------------------
// Copies len bytes from a synchronous-read ROM to a RAM at one byte per clock.
//
// Timeline for a transfer whose start is sampled on edge E0 (cycle n is the
// clock period that ends on edge En):
//   cycle 1          READ : addr_in = src_base, busy = 1, we = 0
//   cycle 2..len+1   XFER : we = 1, addr_out = dst_base + k,
//                           dout = din = ROM[src_base + k],
//                           addr_in = src_base + k + 1
//   cycle len+2      FIN  : done = 1, busy = 0
// With len = 0 the controller goes straight to FIN in cycle 1.
//
// dout follows din combinationally while writing, because the ROM data
// arrives in the same cycle the write must happen. Outside XFER, dout shows a
// register holding the last byte written, so the RAM-side outputs stay
// steady whenever we is low.
//
// Ports
//   clk       clock, rising edge
//   reset     synchronous active-high reset. It has priority over start and
//             aborts a transfer in progress without any done pulse.
//   start     request, accepted only in IDLE
//   src_base  first ROM address (sampled on accepted start)
//   dst_base  first RAM address (sampled on accepted start)
//   len       byte count 0..2^ADDR_W (sampled on accepted start)
//   addr_in   ROM read address
//   din       ROM read data, valid one cycle after addr_in
//   addr_out  RAM write address
//   dout      RAM write data
//   we        RAM write enable
//   busy      transfer in progress (READ or XFER)
//   done      one-cycle completion pulse (FIN)
//   checksum  (only with CHECKSUM_EN defined) sum modulo 2^DATA_W of every
//             byte written. It clears on an accepted start and on reset.
//
// Build option
//   CHECKSUM_EN : adds the checksum output and its accumulator.
// ============================================================================
module mem_copy_ctrl
    import memctl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] dout,
    output logic              we,
    output logic              busy,
    output logic              done
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_e state_q, state_d;

    logic start_ok;        // start seen while idle
    logic len_zero;
    logic load_counters;
    logic last_byte;
    logic [DATA_W-1:0] dout_hold_q;

    assign start_ok      = start && (state_q == IDLE);
    assign len_zero      = (len == '0);
    assign load_counters = start_ok && !len_zero;

    // ------------------------------------------------------------------
    // Address / count generation
    // ------------------------------------------------------------------
    xfer_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (load_counters),
        .prime_i    (state_q == READ),
        .step_i     (state_q == XFER),
        .src_base_i (src_base),
        .dst_base_i (dst_base),
        .len_i      (len),
        .src_addr_o (addr_in),
        .dst_addr_o (addr_out),
        .last_o     (last_byte)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = len_zero ? FIN : READ;
                end
            end
            READ:    state_d = XFER;
            XFER: begin
                if (last_byte) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign we   = (state_q == XFER);
    assign busy = (state_q == READ) || (state_q == XFER);
    assign done = (state_q == FIN);

    // ------------------------------------------------------------------
    // Write data: live ROM data while writing, last written byte otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_hold_q <= '0;
        end else if (we) begin
            dout_hold_q <= din;
        end
    end

    assign dout = we ? din : dout_hold_q;

`ifdef CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running checksum. The last byte is added on the edge that enters FIN,
    // so the value is final while done is high. It then holds until the
    // next accepted start.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            sum_q <= '0;
        end else if (we) begin
            sum_q <= sum_q + din;
        end
    end

    assign checksum = sum_q;
`endif

endmodule : mem_copy_ctrl

// File: tb/tb_mem_copy_ctrl.sv
module tb_mem_copy_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          we;
    logic          busy;
    logic          done;
`ifdef CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    mem_copy_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
        .addr_in  (addr_in),
        .din      (din),
        .addr_out (addr_out),
        .dout     (dout),
        .we       (we),
        .busy     (busy),
        .done     (done)
`ifdef CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // Behavioural memories: synchronous-read ROM, write-enabled RAM
    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] ram [DEPTH];

    always @(posedge clk) din <= rom[addr_in];
    always @(posedge clk) if (we) ram[addr_out] <= dout;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations of the most recent run (cycle numbers relative to start)
    logic [AW-1:0] obs_wa[$];
    logic [DW-1:0] obs_wd[$];
    int            obs_wc[$];
    logic [AW-1:0] obs_ain[$];
    int            obs_done_n;
    int            obs_done_c;
    int            obs_busy_n;
    logic [DW-1:0] obs_sum;

    // Reference helpers: plain modular arithmetic on addresses
    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input int k);
        return AW'((int'(base) + k) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] ref_sum(input logic [AW-1:0] s, input int n);
        int acc = 0;
        for (int k = 0; k < n; k++) acc += int'(rom[wrap(s, k)]);
        return DW'(acc % 256);
    endfunction

    // Launch a transfer and record ncyc cycles of activity. Optionally pulse
    // start again (with ps/pd/pl) in cycle poke_rel, or pulse reset in rst_rel.
    task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l,
                       input int ncyc, input int poke_rel,
                       input logic [AW-1:0] ps, input logic [AW-1:0] pd, input int pl,
                       input int rst_rel);
        obs_wa.delete(); obs_wd.delete(); obs_wc.delete(); obs_ain.delete();
        obs_done_n = 0; obs_done_c = -1; obs_busy_n = 0; obs_sum = '0;
        @(negedge clk);
        src_base = s; dst_base = d; len = (AW+1)'(l); start = 1'b1;
        @(posedge clk);
        for (int rel = 1; rel <= ncyc; rel++) begin
            @(negedge clk);
            start = 1'b0;
            reset = 1'b0;
            if (we) begin
                obs_wa.push_back(addr_out);
                obs_wd.push_back(dout);
                obs_wc.push_back(rel);
            end
            if (busy) obs_busy_n++;
            if (done) begin
                obs_done_n++;
                obs_done_c = rel;
`ifdef CHECKSUM_EN
                obs_sum = checksum;
`endif
            end
            obs_ain.push_back(addr_in);
            if (rel == poke_rel) begin
                src_base = ps; dst_base = pd; len = (AW+1)'(pl); start = 1'b1;
            end
            if (rel == rst_rel) reset = 1'b1;
        end
        $display("xfer src=%0d dst=%0d len=%0d writes=%0d done_cnt=%0d done_cycle=%0d",
                 s, d, l, obs_wa.size(), obs_done_n, obs_done_c);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; len = (AW+1)'(5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (addr_in !== '0) begin n_bad++; $display("FAIL reset_addr_in got=%0h exp=0", addr_in); end
        n_cmp++; if (addr_out !== '0) begin n_bad++; $display("FAIL reset_addr_out got=%0h exp=0", addr_out); end
        n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL reset_dout got=%0h exp=0", dout); end
        n_cmp++; if ({we, busy, done} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got=%b exp=000", {we, busy, done}); end
`ifdef CHECKSUM_EN
        n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL reset_checksum got=%0h exp=0", checksum); end
`endif
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_prio_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i + 1);
        run(0, 0, 4, 10, 0, 0, 0, 0, 0);
        n_cmp++; if (obs_wa.size() != 4) begin n_bad++; $display("FAIL basic_count got=%0d exp=4", obs_wa.size()); end
        for (int k = 0; k < 4 && k < obs_wa.size(); k++) begin
            n_cmp++; if (obs_wa[k] !== AW'(k)) begin n_bad++; $display("FAIL basic_addr k=%0d got=%0d exp=%0d", k, obs_wa[k], k); end
            n_cmp++; if (obs_wd[k] !== DW'(k + 1)) begin n_bad++; $display("FAIL basic_data k=%0d got=%0d exp=%0d", k, obs_wd[k], k + 1); end
            n_cmp++; if (obs_wc[k] != k + 2) begin n_bad++; $display("FAIL basic_cycle k=%0d got=%0d exp=%0d", k, obs_wc[k], k + 2); end
        end
        n_cmp++; if (obs_done_c != 6 || obs_done_n != 1) begin n_bad++; $display("FAIL basic_done got=%0d@%0d exp=1@6", obs_done_n, obs_done_c); end
        n_cmp++; if (obs_busy_n != 5) begin n_bad++; $display("FAIL basic_busy got=%0d exp=5", obs_busy_n); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_rd [3];
        logic [AW-1:0] exp_wr [3];
        exp_rd[0] = 10'd1022; exp_rd[1] = 10'd1023; exp_rd[2] = 10'd0;
        exp_wr[0] = 10'd1023; exp_wr[1] = 10'd0;    exp_wr[2] = 10'd1;
        for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
        run(10'd1022, 10'd1023, 3, 8, 0, 0, 0, 0, 0);
        n_cmp++; if (obs_wa.size() != 3) begin n_bad++; $display("FAIL wrap_count got=%0d exp=3", obs_wa.size()); end
        for (int k = 0; k < 3 && k < obs_wa.size(); k++) begin
            n_cmp++; if (obs_ain[k] !== exp_rd[k]) begin n_bad++; $display("FAIL wrap_read k=%0d got=%0d exp=%0d", k, obs_ain[k], exp_rd[k]); end
            n_cmp++; if (obs_wa[k] !== exp_wr[k]) begin n_bad++; $display("FAIL wrap_write k=%0d got=%0d exp=%0d", k, obs_wa[k], exp_wr[k]); end
            n_cmp++; if (obs_wd[k] !== rom[exp_rd[k]]) begin n_bad++; $display("FAIL wrap_data k=%0d got=%0h exp=%0h", k, obs_wd[k], rom[exp_rd[k]]); end
        end
    endtask

    task automatic test_len0();
        run(10'd77, 10'd99, 0, 5, 0, 0, 0, 0, 0);
        n_cmp++; if (obs_wa.size() != 0) begin n_bad++; $display("FAIL len0_writes got=%0d exp=0", obs_wa.size()); end
        n_cmp++; if (obs_done_c != 1 || obs_done_n != 1) begin n_bad++; $display("FAIL len0_done got=%0d@%0d exp=1@1", obs_done_n, obs_done_c); end
        n_cmp++; if (obs_busy_n != 0) begin n_bad++; $display("FAIL len0_busy got=%0d exp=0", obs_busy_n); end
    endtask

    task automatic test_ignore_start();
        logic [AW-1:0] s, d;
        s = AW'($urandom); d = AW'($urandom);
        run(s, d, 6, 14, 3, AW'($urandom), AW'($urandom), 9, 0);
        n_cmp++; if (obs_wa.size() != 6) begin n_bad++; $display("FAIL ignore_count got=%0d exp=6", obs_wa.size()); end
        for (int k = 0; k < 6 && k < obs_wa.size(); k++) begin
            n_cmp++; if (obs_wa[k] !== wrap(d, k) || obs_wd[k] !== rom[wrap(s, k)])
                begin n_bad++; $display("FAIL ignore_write k=%0d got=%0d/%0h exp=%0d/%0h", k, obs_wa[k], obs_wd[k], wrap(d, k), rom[wrap(s, k)]); end
        end
        n_cmp++; if (obs_done_c != 8 || obs_done_n != 1) begin n_bad++; $display("FAIL ignore_done got=%0d@%0d exp=1@8", obs_done_n, obs_done_c); end
    endtask

    task automatic test_reset_abort();
        run(10'd5, 10'd200, 8, 12, 0, 0, 0, 0, 4);
        n_cmp++; if (obs_wa.size() != 3) begin n_bad++; $display("FAIL abort_writes got=%0d exp=3", obs_wa.size()); end
        n_cmp++; if (obs_done_n != 0) begin n_bad++; $display("FAIL abort_done got=%0d exp=0", obs_done_n); end
        n_cmp++; if (obs_busy_n != 4) begin n_bad++; $display("FAIL abort_busy got=%0d exp=4", obs_busy_n); end
        n_cmp++; if (obs_ain[4] !== '0) begin n_bad++; $display("FAIL abort_addr_in got=%0d exp=0", obs_ain[4]); end
        // Next start behaves normally
        run(10'd40, 10'd60, 2, 7, 0, 0, 0, 0, 0);
        n_cmp++; if (obs_wa.size() != 2 || obs_done_c != 4) begin n_bad++; $display("FAIL abort_restart got=%0d@%0d exp=2@4", obs_wa.size(), obs_done_c); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] s2, d2;
        s2 = AW'($urandom); d2 = AW'($urandom);
        run(10'd300, 10'd400, 3, 16, 6, s2, d2, 4, 0);
        n_cmp++; if (obs_wa.size() != 7) begin n_bad++; $display("FAIL b2b_count got=%0d exp=7", obs_wa.size()); end
        n_cmp++; if (obs_done_n != 2 || obs_done_c != 12) begin n_bad++; $display("FAIL b2b_done got=%0d@%0d exp=2@12", obs_done_n, obs_done_c); end
        for (int k = 0; k < 4 && k + 3 < obs_wa.size(); k++) begin
            n_cmp++; if (obs_wa[k+3] !== wrap(d2, k) || obs_wd[k+3] !== rom[wrap(s2, k)] || obs_wc[k+3] != k + 8)
                begin n_bad++; $display("FAIL b2b_write k=%0d got=%0d/%0h@%0d exp=%0d/%0h@%0d", k, obs_wa[k+3], obs_wd[k+3], obs_wc[k+3], wrap(d2, k), rom[wrap(s2, k)], k + 8); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] s, d;
            int l;
            for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
            s = AW'($urandom); d = AW'($urandom); l = int'($urandom_range(1, 40));
            run(s, d, l, l + 6, 0, 0, 0, 0, 0);
            n_cmp++; if (obs_wa.size() != l) begin n_bad++; $display("FAIL rand_count t=%0d got=%0d exp=%0d", t, obs_wa.size(), l); end
            for (int k = 0; k < l && k < obs_wa.size(); k++) begin
                n_cmp++; if (obs_wa[k] !== wrap(d, k) || obs_wd[k] !== rom[wrap(s, k)] || obs_wc[k] != k + 2)
                    begin n_bad++; $display("FAIL rand_write t=%0d k=%0d got=%0d/%0h@%0d exp=%0d/%0h@%0d", t, k, obs_wa[k], obs_wd[k], obs_wc[k], wrap(d, k), rom[wrap(s, k)], k + 2); end
                n_cmp++; if (obs_ain[k] !== wrap(s, k)) begin n_bad++; $display("FAIL rand_read t=%0d k=%0d got=%0d exp=%0d", t, k, obs_ain[k], wrap(s, k)); end
            end
            n_cmp++; if (obs_done_n != 1 || obs_done_c != l + 2) begin n_bad++; $display("FAIL rand_done t=%0d got=%0d@%0d exp=1@%0d", t, obs_done_n, obs_done_c, l + 2); end
`ifdef CHECKSUM_EN
            n_cmp++; if (obs_sum !== ref_sum(s, l)) begin n_bad++; $display("FAIL rand_checksum t=%0d got=%0h exp=%0h", t, obs_sum, ref_sum(s, l)); end
`endif
        end
    endtask

    task automatic test_full();
        int bad_ram;
        int bad_wr;
        for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i);
        run(10'd341, 10'd682, DEPTH, DEPTH + 6, 0, 0, 0, 0, 0);
        n_cmp++; if (obs_wa.size() != DEPTH) begin n_bad++; $display("FAIL full_count got=%0d exp=%0d", obs_wa.size(), DEPTH); end
        bad_wr = 0;
        for (int k = 0; k < DEPTH && k < obs_wa.size(); k++)
            if (obs_wa[k] !== wrap(10'd682, k) || obs_wd[k] !== rom[wrap(10'd341, k)]) bad_wr++;
        n_cmp++; if (bad_wr != 0) begin n_bad++; $display("FAIL full_writes got=%0d_bad exp=0_bad", bad_wr); end
        @(negedge clk);
        bad_ram = 0;
        for (int k = 0; k < DEPTH; k++) if (ram[wrap(10'd682, k)] !== rom[wrap(10'd341, k)]) bad_ram++;
        n_cmp++; if (bad_ram != 0) begin n_bad++; $display("FAIL full_ram got=%0d_bad exp=0_bad", bad_ram); end
        n_cmp++; if (obs_done_c != DEPTH + 2) begin n_bad++; $display("FAIL full_done got=%0d exp=%0d", obs_done_c, DEPTH + 2); end
`ifdef CHECKSUM_EN
        n_cmp++; if (obs_sum !== ref_sum(10'd341, DEPTH)) begin n_bad++; $display("FAIL full_checksum got=%0h exp=%0h", obs_sum, ref_sum(10'd341, DEPTH)); end
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = '0;
            ram[i] = '0;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_len0();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_copy_ctrl
